// File: rtl/cdc_uart_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : cdc_uart_bridge_if
// Purpose  : Byte-stream handshake bundle between usb_cdc_core and the
//            UART bridge. The outport carries Host->Device bytes.
//            The inport carries Device->Host bytes.
// Revision : 1.0 - initial release
// ============================================================================
interface cdc_uart_bridge_if;
  logic       outport_valid_i;
  logic [7:0] outport_data_i;
  logic       outport_accept_o;
  logic       inport_valid_o;
  logic [7:0] inport_data_o;
  logic       inport_accept_i;

  // CDC core side: produces outport bytes and consumes inport bytes
  modport master (
    output outport_valid_i, outport_data_i, inport_accept_i,
    input  outport_accept_o, inport_valid_o, inport_data_o
  );

  // Bridge side
  modport slave (
    input  outport_valid_i, outport_data_i, inport_accept_i,
    output outport_accept_o, inport_valid_o, inport_data_o
  );
endinterface
`default_nettype wire

// File: rtl/cdc_uart_bridge.sv
`default_nettype none
// ============================================================================
// Module   : cdc_uart_bridge
// Purpose  : Buffered byte bridge between the USB CDC byte streams and a
//            UART pin pair. It has a TX FIFO feeding a serialiser, and a
//            deserialiser feeding an RX FIFO with first-word-fall-through
//            reads. Everything runs on clk_i.
// Options  : CDC_UART_PARITY_EN - when defined, frames are 8E1 (even parity
//            bit between bit7 and stop). Otherwise frames are 8N1.
// Revision : 1.0 - initial release
// ============================================================================
module cdc_uart_bridge #(
  parameter int BAUD_DIV   = 520,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  cdc_uart_bridge_if.slave            cdc,
  input  logic                        uart_rx_i,
  output logic                        uart_tx_o,
  output logic                        rx_overflow_o,
  output logic                        frame_err_o,
  output logic [$clog2(FIFO_DEPTH):0] tx_level_o,
  output logic [$clog2(FIFO_DEPTH):0] rx_level_o
);
  localparam int              AW       = $clog2(FIFO_DEPTH);
  localparam int              LW       = AW + 1;
  localparam logic [LW-1:0]   DEPTH_L  = LW'(FIFO_DEPTH);
  localparam logic [15:0]     BIT_M1   = 16'(BAUD_DIV - 1);
  localparam logic [15:0]     HALF_BIT = 16'(BAUD_DIV / 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

  // ---------------- TX FIFO ----------------
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wr, tx_rd;
  logic [LW-1:0] tx_level;
  logic          tx_full, tx_empty, tx_push, tx_pop;

  // ---------------- TX serialiser ----------------
  uart_state_t   tx_state;
  logic [15:0]   tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_sh;
`ifdef CDC_UART_PARITY_EN
  logic          tx_par;
`endif

  // ---------------- RX FIFO ----------------
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wr, rx_rd;
  logic [LW-1:0] rx_level;
  logic          rx_full, rx_empty, rx_push, rx_pop;

  // ---------------- RX deserialiser ----------------
  logic          rx_s1, rx_s2, rx_prev;
  uart_state_t   rx_state;
  logic [15:0]   rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rx_par_err;

  assign tx_full              = (tx_level == DEPTH_L);
  assign tx_empty             = (tx_level == '0);
  assign cdc.outport_accept_o = !tx_full;
  assign tx_push              = cdc.outport_valid_i && !tx_full;
  // The serialiser takes a byte when idle or at the end of a stop bit.
  // Taking it at the end of the stop bit avoids an idle gap between frames.
  assign tx_pop  = !tx_empty &&
                   ((tx_state == IDLE) || ((tx_state == STOP) && (tx_cnt == '0)));
  assign tx_level_o = tx_level;

  assign rx_full              = (rx_level == DEPTH_L);
  assign rx_empty             = (rx_level == '0);
  assign cdc.inport_valid_o   = !rx_empty;
  // Masking with empty makes the output read 0 after reset, even though the storage itself is not reset.
  assign cdc.inport_data_o    = rx_empty ? 8'h00 : rx_mem[rx_rd];
  assign rx_pop               = !rx_empty && cdc.inport_accept_i;
  // Push on a good stop sample. When the FIFO is full, a pop in the same cycle frees the slot.
  assign rx_push = (rx_state == STOP) && (rx_cnt == '0) && rx_s2 && !rx_par_err &&
                   (!rx_full || rx_pop);
  assign rx_level_o = rx_level;

  // FIFO storage writes (storage needs no reset)
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wr] <= cdc.outport_data_i;
    if (rx_push) rx_mem[rx_wr] <= rx_sh;
  end

  // FIFO pointers and occupancy counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_wr <= '0; tx_rd <= '0; tx_level <= '0;
      rx_wr <= '0; rx_rd <= '0; rx_level <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      if (tx_push && !tx_pop)      tx_level <= tx_level + 1'b1;
      else if (!tx_push && tx_pop) tx_level <= tx_level - 1'b1;
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      if (rx_push && !rx_pop)      rx_level <= rx_level + 1'b1;
      else if (!rx_push && rx_pop) rx_level <= rx_level - 1'b1;
    end
  end

  // TX FSM: each bit is held BAUD_DIV cycles, LSB first, with a registered line output
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state  <= IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_sh     <= '0;
      uart_tx_o <= 1'b1;
`ifdef CDC_UART_PARITY_EN
      tx_par    <= 1'b0;
`endif
    end else begin
      case (tx_state)
        IDLE: begin
          if (!tx_empty) begin
            tx_sh     <= tx_mem[tx_rd];
`ifdef CDC_UART_PARITY_EN
            tx_par    <= ^tx_mem[tx_rd];
`endif
            uart_tx_o <= 1'b0;
            tx_cnt    <= BIT_M1;
            tx_state  <= START;
          end
        end
        START: begin
          if (tx_cnt == '0) begin
            uart_tx_o <= tx_sh[0];
            tx_sh     <= tx_sh >> 1;
            tx_bit    <= '0;
            tx_cnt    <= BIT_M1;
            tx_state  <= DATA;
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= BIT_M1;
            if (tx_bit == 3'd7) begin
`ifdef CDC_UART_PARITY_EN
              uart_tx_o <= tx_par;
              tx_state  <= PARITY;
`else
              uart_tx_o <= 1'b1;
              tx_state  <= STOP;
`endif
            end else begin
              uart_tx_o <= tx_sh[0];
              tx_sh     <= tx_sh >> 1;
              tx_bit    <= tx_bit + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
`ifdef CDC_UART_PARITY_EN
        PARITY: begin
          if (tx_cnt == '0) begin
            uart_tx_o <= 1'b1;
            tx_cnt    <= BIT_M1;
            tx_state  <= STOP;
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
`endif
        STOP: begin
          if (tx_cnt == '0) begin
            if (!tx_empty) begin
              tx_sh     <= tx_mem[tx_rd];
`ifdef CDC_UART_PARITY_EN
              tx_par    <= ^tx_mem[tx_rd];
`endif
              uart_tx_o <= 1'b0;
              tx_cnt    <= BIT_M1;
              tx_state  <= START;
            end else begin
              tx_state <= IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        default: begin
          uart_tx_o <= 1'b1;
          tx_state  <= IDLE;
        end
      endcase
    end
  end

  // Two-flop synchroniser for the asynchronous RX pin, plus a delayed copy for falling-edge detection
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx_i;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

`ifndef CDC_UART_PARITY_EN
  assign rx_par_err = 1'b0;
`endif

  // RX FSM: first sample at half a bit after the start edge, then one sample per bit period
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_state      <= IDLE;
      rx_cnt        <= '0;
      rx_bit        <= '0;
      rx_sh         <= '0;
      rx_overflow_o <= 1'b0;
      frame_err_o   <= 1'b0;
`ifdef CDC_UART_PARITY_EN
      rx_par_err    <= 1'b0;
`endif
    end else begin
      frame_err_o <= 1'b0;
      case (rx_state)
        IDLE: begin
          // A start needs a real high-to-low transition, so a line stuck low after a bad frame is ignored
          if (rx_prev && !rx_s2) begin
            rx_cnt   <= HALF_BIT;
            rx_state <= START;
          end
        end
        START: begin
          if (rx_cnt == '0) begin
            if (rx_s2) begin
              rx_state <= IDLE;
            end else begin
              rx_cnt   <= BIT_M1;
              rx_bit   <= '0;
              rx_state <= DATA;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        DATA: begin
          if (rx_cnt == '0) begin
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_cnt <= BIT_M1;
            if (rx_bit == 3'd7) begin
`ifdef CDC_UART_PARITY_EN
              rx_state <= PARITY;
`else
              rx_state <= STOP;
`endif
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
`ifdef CDC_UART_PARITY_EN
        PARITY: begin
          if (rx_cnt == '0) begin
            rx_par_err  <= (rx_s2 != ^rx_sh);
            frame_err_o <= (rx_s2 != ^rx_sh);
            rx_cnt      <= BIT_M1;
            rx_state    <= STOP;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
`endif
        STOP: begin
          if (rx_cnt == '0) begin
            // A frame that already failed parity has been reported and is not reported again here
            if (!rx_s2 && !rx_par_err)
              frame_err_o <= 1'b1;
            else if (rx_s2 && !rx_par_err && rx_full && !rx_pop)
              rx_overflow_o <= 1'b1;
            rx_state <= IDLE;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire
